// File: rtl/counting_pkg.sv
// Shared types for the time-multiplexed "1,2,3" detector.
package counting_pkg;

    localparam int SYM_W = 2;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

endpackage

// File: rtl/counting_step.sv
// One step of the "1,2,3" sequence detector; shared by all channels.
module counting_step
    import counting_pkg::*;
(
    input  state_t             cur_state,
    input  logic [SYM_W-1:0]   num,
    output state_t             nxt_state,
    output logic               is_hit
);

    always_comb begin
        nxt_state = S0;
        unique case (num)
            2'd1: nxt_state = S1;
            2'd2: nxt_state = (cur_state == S1 || cur_state == S2) ? S2 : S0;
            2'd3: nxt_state = (cur_state == S2 || cur_state == S3) ? S3 : S0;
            default: nxt_state = S0;
        endcase
    end

    assign is_hit = (nxt_state == S3);

endmodule

// File: rtl/counting_arbiter.sv
// Round-robin arbiter sharing one detector step among NCH symbol streams,
// with per-channel saved state and saturating hit counters.
module counting_arbiter
    import counting_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic [NCH-1:0]         req_valid,
    input  logic [SYM_W*NCH-1:0]   req_num,
    output logic [NCH-1:0]         req_ready,
    output logic [NCH-1:0]         ans,
    output logic                   hit_valid,
    output logic [1:0]             hit_ch,
    output logic [CNT_W*NCH-1:0]   hit_cnt
);

    state_t             state_q [NCH];
    state_t             state_d [NCH];
    logic [CNT_W-1:0]   cnt_q   [NCH];
    logic [CNT_W-1:0]   cnt_d   [NCH];
    logic [1:0]         last_q, last_d;
    logic               hit_valid_q, hit_valid_d;
    logic [1:0]         hit_ch_q, hit_ch_d;

    logic [3:0]         valid_pad;
    logic [2:0]         scan;
    logic [1:0]         gnt_idx;
    logic               gnt_found;
    state_t             cur_state, nxt_state;
    logic [SYM_W-1:0]   cur_num;
    logic               is_hit;

    assign valid_pad = 4'(req_valid);

    // Scan upward from the channel after the last grant, wrapping at NCH.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        scan      = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan = 3'(last_q) + 3'(k);
            if (scan >= 3'(NCH)) scan = scan - 3'(NCH);
            if (!gnt_found && valid_pad[scan[1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[1:0];
            end
        end
        if (clr) begin
            gnt_found = 1'b0;
            gnt_idx   = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        cur_state = S0;
        cur_num   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (2'(i) == gnt_idx) begin
                req_ready[i] = gnt_found;
                cur_state    = state_q[i];
                cur_num      = req_num[SYM_W*i +: SYM_W];
            end
        end
    end

    counting_step u_step (
        .cur_state (cur_state),
        .num       (cur_num),
        .nxt_state (nxt_state),
        .is_hit    (is_hit)
    );

    always_comb begin
        last_d      = last_q;
        hit_valid_d = 1'b0;
        hit_ch_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                state_d[i] = S0;
                cnt_d[i]   = '0;
            end
        end else if (gnt_found) begin
            last_d      = gnt_idx;
            hit_valid_d = is_hit;
            hit_ch_d    = is_hit ? gnt_idx : 2'd0;
            for (int i = 0; i < NCH; i++) begin
                if (2'(i) == gnt_idx) begin
                    state_d[i] = nxt_state;
                    if (is_hit && cnt_q[i] != '1)
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= 2'(NCH - 1);
            hit_valid_q <= 1'b0;
            hit_ch_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S0;
                cnt_q[i]   <= '0;
            end
        end else begin
            last_q      <= last_d;
            hit_valid_q <= hit_valid_d;
            hit_ch_q    <= hit_ch_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        ans     = '0;
        hit_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            ans[i]                   = (state_q[i] == S3);
            hit_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_ch    = hit_ch_q;

endmodule

// File: tb/tb_counting_arbiter.sv
// Self-checking bench for counting_arbiter (3 channels, 2-bit counters).
module tb_counting_arbiter;

    localparam int NCH   = 3;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic [2:0] req_valid;
    logic [5:0] req_num;
    logic [2:0] req_ready;
    logic [2:0] ans;
    logic       hit_valid;
    logic [1:0] hit_ch;
    logic [5:0] hit_cnt;

    always #5 clk = ~clk;

    counting_arbiter #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_ready (req_ready),
        .ans       (ans),
        .hit_valid (hit_valid),
        .hit_ch    (hit_ch),
        .hit_cnt   (hit_cnt)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: per-channel symbol history since last reset/clear
    int   hist [NCH][$];
    int   m_cnt [NCH];
    int   m_last = NCH - 1;
    bit   m_hv;
    int   m_hch;
    int   mg;
    int   pulses;
    logic [2:0] rdy_s;

    // In S3 exactly when the history ends with 1, one or more 2s, one or more 3s.
    function automatic bit in_s3(input int q[$]);
        int i;
        int n3;
        int n2;
        i  = q.size() - 1;
        n3 = 0;
        n2 = 0;
        while (i >= 0 && q[i] == 3) begin n3++; i--; end
        if (n3 == 0) return 1'b0;
        while (i >= 0 && q[i] == 2) begin n2++; i--; end
        if (n2 == 0) return 1'b0;
        return (i >= 0 && q[i] == 1);
    endfunction

    // Valid channel with the smallest forward distance past the last grant.
    function automatic int model_grant(input logic [2:0] v, input bit c);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = NCH + 1;
        if (c) return -1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (v[ch]) begin
                d = (ch - m_last - 1 + 2 * NCH) % NCH;
                if (d < bd) begin bd = d; best = ch; end
            end
        end
        return best;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic apply(input bit r, input bit c,
                         input logic [2:0] v, input logic [5:0] n);
        int e_ans;
        int e_cnt;
        @(negedge clk);
        reset     = r;
        clr       = c;
        req_valid = v;
        req_num   = n;
        #1;
        mg    = model_grant(v, c);
        rdy_s = req_ready;
        check("ready", int'(req_ready), (mg < 0) ? 0 : (1 << mg));
        @(posedge clk);
        if (r) begin
            for (int ch = 0; ch < NCH; ch++) begin
                hist[ch].delete();
                m_cnt[ch] = 0;
            end
            m_last = NCH - 1;
            m_hv   = 1'b0;
            m_hch  = 0;
        end else if (c) begin
            for (int ch = 0; ch < NCH; ch++) begin
                hist[ch].delete();
                m_cnt[ch] = 0;
            end
            m_hv  = 1'b0;
            m_hch = 0;
        end else begin
            m_hv  = 1'b0;
            m_hch = 0;
            if (mg >= 0) begin
                hist[mg].push_back(int'(n[2*mg +: 2]));
                if (hist[mg].size() > 64) void'(hist[mg].pop_front());
                if (in_s3(hist[mg])) begin
                    m_hv  = 1'b1;
                    m_hch = mg;
                    if (m_cnt[mg] < CMAX) m_cnt[mg]++;
                end
                m_last = mg;
            end
        end
        #1;
        e_ans = 0;
        e_cnt = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (in_s3(hist[ch])) e_ans |= (1 << ch);
            e_cnt |= m_cnt[ch] << (CNT_W * ch);
        end
        check("hit_valid", int'(hit_valid), int'(m_hv));
        check("hit_ch", int'(hit_ch), m_hch);
        check("ans", int'(ans), e_ans);
        check("hit_cnt", int'(hit_cnt), e_cnt);
        if (hit_valid) pulses++;
    endtask

    typedef struct packed {
        logic       rst;
        logic       c;
        logic [2:0] v;
        logic [5:0] n;
        logic [2:0] rdy;
        logic       hv;
        logic [1:0] hch;
        logic [2:0] an;
        logic [5:0] cnt;
    } vec_t;

    vec_t tab[$];

    task automatic run_stream(input int syms[$], input int exp_hits, input string nm);
        apply(1'b1, 1'b0, 3'b000, 6'd0);
        pulses = 0;
        foreach (syms[i]) apply(1'b0, 1'b0, 3'b100, 6'(syms[i] << 4));
        apply(1'b0, 1'b0, 3'b000, 6'd0);
        check(nm, pulses, exp_hits);
    endtask

    function automatic int new_sym();
        int k;
        k = int'($urandom % 10);
        if (k == 0) return 0;
        if (k <= 3) return 1;
        if (k <= 6) return 2;
        return 3;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   sat_exp [5];
        int   pend [NCH];
        bit   r;
        bit   c;
        logic [2:0] v;
        logic [5:0] n;

        reset     = 1'b1;
        clr       = 1'b0;
        req_valid = '0;
        req_num   = '0;

        // Single channel 1,2,3,3,0 then two interleaved channels
        tab.push_back('{1'b1, 1'b0, 3'b000, 6'd0,       3'b000, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b001, 6'd1,       3'b001, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b001, 6'd2,       3'b001, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b001, 6'd3,       3'b001, 1'b1, 2'd0, 3'b001, 6'd1});
        tab.push_back('{1'b0, 1'b0, 3'b001, 6'd3,       3'b001, 1'b1, 2'd0, 3'b001, 6'd2});
        tab.push_back('{1'b0, 1'b0, 3'b001, 6'd0,       3'b001, 1'b0, 2'd0, 3'b000, 6'd2});
        tab.push_back('{1'b0, 1'b0, 3'b000, 6'd0,       3'b000, 1'b0, 2'd0, 3'b000, 6'd2});
        tab.push_back('{1'b1, 1'b0, 3'b000, 6'd0,       3'b000, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b011, 6'b000101,  3'b001, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b011, 6'b000110,  3'b010, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b011, 6'b001010,  3'b001, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b011, 6'b001011,  3'b010, 1'b0, 2'd0, 3'b000, 6'd0});
        tab.push_back('{1'b0, 1'b0, 3'b011, 6'b001111,  3'b001, 1'b1, 2'd0, 3'b001, 6'b000001});
        tab.push_back('{1'b0, 1'b0, 3'b011, 6'b001100,  3'b010, 1'b1, 2'd1, 3'b011, 6'b000101});
        tab.push_back('{1'b0, 1'b0, 3'b001, 6'b000000,  3'b001, 1'b0, 2'd0, 3'b010, 6'b000101});

        foreach (tab[i]) begin
            apply(tab[i].rst, tab[i].c, tab[i].v, tab[i].n);
            check($sformatf("tab%0d_ready", i), int'(rdy_s), int'(tab[i].rdy));
            check($sformatf("tab%0d_hv", i), int'(hit_valid), int'(tab[i].hv));
            check($sformatf("tab%0d_hch", i), int'(hit_ch), int'(tab[i].hch));
            check($sformatf("tab%0d_ans", i), int'(ans), int'(tab[i].an));
            check($sformatf("tab%0d_cnt", i), int'(hit_cnt), int'(tab[i].cnt));
        end

        run_stream('{1, 2, 2, 2, 3}, 1, "stream_12223");
        run_stream('{1, 2, 1, 2, 3}, 1, "stream_12123");
        run_stream('{1, 3}, 0, "stream_13");
        run_stream('{1, 2, 0, 3}, 0, "stream_1203");

        // Saturation of a 2-bit counter
        sat_exp = '{1, 2, 3, 3, 3};
        apply(1'b1, 1'b0, 3'b000, 6'd0);
        apply(1'b0, 1'b0, 3'b001, 6'd1);
        apply(1'b0, 1'b0, 3'b001, 6'd2);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 3'b001, 6'd3);
            check($sformatf("sat%0d_cnt", i), int'(hit_cnt[1:0]), sat_exp[i]);
            check($sformatf("sat%0d_hv", i), int'(hit_valid), 1);
        end

        // clr while ch1 presents 3 in S2; last_grant (=1) must survive
        apply(1'b1, 1'b0, 3'b000, 6'd0);
        apply(1'b0, 1'b0, 3'b010, 6'd1 << 2);
        apply(1'b0, 1'b0, 3'b010, 6'd2 << 2);
        apply(1'b0, 1'b0, 3'b010, 6'd3 << 2);
        apply(1'b0, 1'b0, 3'b010, 6'd1 << 2);
        apply(1'b0, 1'b0, 3'b010, 6'd2 << 2);
        check("pre_clr_cnt", int'(hit_cnt), 6'b000100);
        apply(1'b0, 1'b1, 3'b011, 6'b001101);
        check("clr_ready", int'(rdy_s), 0);
        check("clr_hv", int'(hit_valid), 0);
        check("clr_cnt", int'(hit_cnt), 0);
        check("clr_ans", int'(ans), 0);
        apply(1'b0, 1'b0, 3'b111, 6'b010101);
        check("clr_resume", int'(rdy_s), 3'b100);
        apply(1'b0, 1'b0, 3'b010, 6'd3 << 2);
        check("clr_no_hit", int'(hit_valid), 0);

        // Reset colliding with a hit-producing accept, then reset after a hit
        apply(1'b1, 1'b0, 3'b000, 6'd0);
        apply(1'b0, 1'b0, 3'b001, 6'd1);
        apply(1'b0, 1'b0, 3'b001, 6'd2);
        apply(1'b1, 1'b0, 3'b001, 6'd3);
        check("rst_acc_hv", int'(hit_valid), 0);
        check("rst_acc_cnt", int'(hit_cnt), 0);
        apply(1'b0, 1'b0, 3'b001, 6'd1);
        apply(1'b0, 1'b0, 3'b001, 6'd2);
        apply(1'b0, 1'b0, 3'b001, 6'd3);
        check("pre_rst_hv", int'(hit_valid), 1);
        apply(1'b1, 1'b0, 3'b000, 6'd0);
        check("rst_hv", int'(hit_valid), 0);
        check("rst_cnt", int'(hit_cnt), 0);
        apply(1'b0, 1'b0, 3'b111, 6'b010101);
        check("rst_first_grant", int'(rdy_s), 3'b001);

        // Randomized traffic against the model
        apply(1'b1, 1'b0, 3'b000, 6'd0);
        for (int ch = 0; ch < NCH; ch++) pend[ch] = new_sym();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = ($urandom % 150) == 0;
            c = ($urandom % 40) == 0;
            for (int ch = 0; ch < NCH; ch++) begin
                v[ch]        = ($urandom % 10) < 7;
                n[2*ch +: 2] = 2'(pend[ch]);
            end
            apply(r, c, v, n);
            if (!r && mg >= 0) pend[mg] = new_sym();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counting_arbiter.md
Name: counting_arbiter

Overview:
Time-multiplexes one shared "1,2,3" sequence-detector step function among NCH independent symbol streams.
- Each channel keeps its own saved detector state and hit counter.
- A round-robin arbiter grants at most one channel per cycle.
- Sits between the symbol producers and the statistics/readout logic that consumes per-channel match counts.

Parameters:
NCH, 2, number of requesting channels; legal range 2..4.
CNT_W, 8, width of each per-channel saturating hit counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of all channel states and counters; reset-equivalent except last_grant is kept.
req_valid  input  NCH  per-channel symbol valid.
req_num  input  2*NCH  per-channel 2-bit symbol; channel i at bits [2i+1:2i].
req_ready  output  NCH  combinational one-hot grant; symbol is accepted when valid and ready are both high at a clock edge.
ans  output  NCH  registered level; bit i = 1 iff channel i saved state == S3.
hit_valid  output  1  registered 1-cycle pulse: the symbol accepted in the previous cycle moved its channel into S3.
hit_ch  output  2  channel index for hit_valid; 0 when hit_valid = 0.
hit_cnt  output  CNT_W*NCH  per-channel hit counters, flat; channel i at [CNT_W*(i+1)-1 : CNT_W*i].

Behaviour:
Reset (reset = 1 at edge):
- All channel states = S0.
- All counters = 0.
- last_grant = NCH-1, so channel 0 has first priority.
- hit_valid = 0, hit_ch = 0.
- ans = 0.
- reset overrides clr and any accept.

Detector step (per accepted symbol, applied to that channel's state only):
- S0: num==1 -> S1; otherwise S0.
- S1: 2 -> S2; 1 -> S1; otherwise S0.
- S2: 3 -> S3; 2 -> S2; 1 -> S1; otherwise S0.
- S3: 3 -> S3; 1 -> S1; otherwise S0.
- Symbol 0 always returns the channel to S0.

Arbitration:
- Search for a valid channel starting at last_grant+1, wrapping modulo NCH; the first valid channel found is granted.
- req_ready is one-hot, or all-zero when no channel is valid.
- req_ready may depend combinationally on req_valid.
- On accept, last_grant <= granted index. With no accept, last_grant holds.
- Non-granted channels keep state; their pending symbols stay presented and are not consumed.

Hit accounting:
- If the next state is S3, then on the following cycle hit_valid = 1 and hit_ch = the channel index.
- On the same edge, that channel's counter increments.
- The counter saturates at 2^CNT_W-1 and holds there. hit_valid still pulses when saturated.
- Consecutive 3s while in S3 each count as a hit.

Timing:
- Latency from accept to ans, hit_valid and hit_cnt update is 1 cycle.
- Throughput is one symbol per cycle in aggregate.

clr:
- While clr = 1, req_ready = 0, so nothing is accepted.
- At the edge, states -> S0, counters -> 0, hit_valid -> 0.
- last_grant is unchanged.

Mid-stream reset:
- Any in-flight hit pulse is dropped.
- No partial counter update.

Decomposition:
Package counting_pkg:
- 2-bit state typedef and constants S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.
- Symbol width constant SYM_W = 2.

Sub-module counting_step:
- Purely combinational next-state function: inputs cur_state and num; outputs nxt_state and is_hit (nxt_state == S3).
- Exactly one instance, shared by all channels through the grant mux.

Test Plan:
1. Reset, then channel 0 alone sends 1,2,3,3,0 -> hit_valid pulses after the 3rd and 4th symbols with hit_ch=0; hit_cnt ch0 = 2; ans[0] is high for 2 cycles, then 0.
2. Channels 0 and 1 both valid every cycle, with ch0 sending 1,2,3 and ch1 sending 1,2,3 -> grants alternate 0,1,0,1,0,1. Hits occur on ch0 at cycle 6 and ch1 at cycle 7; ch0 and ch1 counters both end at 1. Interleaving must not corrupt either channel's state.
3. Stream 1,2,2,2,3 on one channel -> exactly 1 hit. Stream 1,2,1,2,3 -> 1 hit. Stream 1,3 -> 0 hits. Stream 1,2,0,3 -> 0 hits.
4. Saturation with CNT_W=2: 1,2,3 then 3,3,3,3 -> counter reads 1,2,3,3,3; hit_valid pulses all 5 times.
5. Assert clr on the same cycle ch1 presents 3 while in S2 -> req_ready = 0; after the edge all states S0, counters 0, no hit. Next cycle the arbiter resumes from the preserved last_grant.
6. Assert reset on the cycle after a hit-producing accept -> hit_valid = 0 after that edge; all counters 0; first grant goes to channel 0.
